regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
Parametrised CPU register file. It holds a bank of short general registers and a bank of wide long registers in one flat index space, with two combinational read ports and one synchronous write port. A per-register busy scoreboard lets multi-cycle units reserve a destination register and release it on writeback. The decode stage uses the busy flags to stall.

Parameters:
NUM_SHORT, 28, number of short registers; they occupy indices 0..NUM_SHORT-1.
SHORT_WIDTH, 16, bit width of each short register.
NUM_LONG, 4, number of long registers; they occupy indices NUM_SHORT..NUM_SHORT+NUM_LONG-1.
LONG_WIDTH, 24, bit width of each long register; must be >= SHORT_WIDTH.
IDX_W, 5, index width; must satisfy 2^IDX_W >= NUM_SHORT+NUM_LONG.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous reset, active-high.
read_index_1  in  IDX_W  read port 1 address.
read_data_1  out  LONG_WIDTH  read port 1 data.
read_busy_1  out  1  busy flag of read_index_1.
read_index_2  in  IDX_W  read port 2 address.
read_data_2  out  LONG_WIDTH  read port 2 data.
read_busy_2  out  1  busy flag of read_index_2.
write_enable  in  1  write strobe.
write_index  in  IDX_W  write address.
write_data  in  LONG_WIDTH  write data.
reserve_valid  in  1  request to mark reserve_index busy.
reserve_index  in  IDX_W  register to reserve.
reserve_ready  out  1  reservation accepted this cycle.
busy_count  out  IDX_W+1  number of registers currently busy.

Behaviour:
- Clocking: the single clock is clk. Reset is synchronous and active-high on reset.
- Reset: on a rising clk edge with reset=1, all registers clear to 0, all busy bits clear to 0, and busy_count goes to 0. Reset overrides any write or reserve in the same cycle.
- After reset, both read_data outputs read 0, both read_busy outputs read 0, and reserve_ready equals reserve_valid.
- Read:
  - Combinational, zero latency.
  - A short register is zero-extended to LONG_WIDTH.
  - An out-of-range index (>= NUM_SHORT+NUM_LONG) returns 0 with busy 0.
- Write:
  - Takes effect at the rising edge when write_enable=1.
  - A short target stores write_data[SHORT_WIDTH-1:0]; a long target stores the full width.
  - An out-of-range write_index is ignored.
  - A write clears the target's busy bit.
- Reserve handshake:
  - reserve_ready = reserve_valid AND index in range AND NOT busy[reserve_index].
  - When reserve_valid & reserve_ready, busy[reserve_index] sets at the edge.
  - A requester holds reserve_valid and reserve_index stable until reserve_ready is seen. Changing them while not ready is legal; the block keeps no request state.
- Simultaneous write and reserve, same index:
  - reserve_ready is evaluated against the pre-edge busy bit. If that bit is busy, ready=0.
  - If accepted, the data is written and the busy bit ends set: the reserve wins.
- Simultaneous write and reserve, different indices: both take effect.
- busy_count:
  - Registered; always equals the popcount of the busy bits after the edge.
  - Per edge it changes by -1, 0 or +1. A write that clears busy, together with an accepted reserve elsewhere, nets 0.
- Writing a non-busy register leaves busy unchanged.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: when write_enable=1 and write_index==read_index_N (in range), read_data_N returns the value being written in the same cycle, truncated and zero-extended as for a short target. read_busy_N returns 0 unless the same-index reserve is also accepted.
- Undefined: reads return the pre-edge stored value and pre-edge busy. The new value is visible from the next cycle.

Test Plan:
- Reset then read: assert reset 1 cycle, then read indices 0 and 31 -> read_data_1=0, read_data_2=0, busy_count=0.
- Width rules: write 0xABCDEF to index 3 and to index 29, then read both -> index 3 reads 0x00CDEF, index 29 reads 0xABCDEF.
- Reserve/release:
  - Reserve index 5 -> busy_count=1 and read_busy_1=1 at index 5.
  - Second reserve of 5 -> reserve_ready=0.
  - Write 0x1234 to 5 -> busy clears, busy_count=0, and index 5 reads 0x1234.
- Same-cycle write and reserve of index 7 (7 not busy) -> after the edge, index 7 = written data, busy[7]=1, busy_count=1.
- Bypass: write 0x0042 to index 2 while read_index_2=2 -> with REGFILE_BYPASS_EN, read_data_2=0x0042 in the same cycle; without it, the old value until the next cycle.
- Mid-operation reset: reserve 3 registers, then assert reset together with write_enable to 1 -> all busy cleared, busy_count=0, target register=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// CPU register file with a busy scoreboard. Short registers (indices
// 0..NUM_SHORT-1, SHORT_WIDTH bits) and long registers (indices
// NUM_SHORT..NUM_SHORT+NUM_LONG-1, LONG_WIDTH bits) share one index space.
// Two combinational read ports, one synchronous write port, and a reserve
// handshake that marks a destination busy until its writeback.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   read_index_N                read port N address (N = 1, 2)
//   read_data_N                 read data, short registers zero-extended
//   read_busy_N                 busy flag of read_index_N
//   write_enable/index/data     write port; a write clears the target's busy bit
//   reserve_valid/index         request to mark reserve_index busy
//   reserve_ready               reservation accepted this cycle
//   busy_count                  registered popcount of the busy bits
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a read whose index matches an in-range write in the same
//   cycle returns the value being written (and the post-edge busy state).
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int unsigned NUM_SHORT   = 28,
    parameter int unsigned SHORT_WIDTH = 16,
    parameter int unsigned NUM_LONG    = 4,
    parameter int unsigned LONG_WIDTH  = 24,
    parameter int unsigned IDX_W       = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IDX_W-1:0]      read_index_1,
    output logic [LONG_WIDTH-1:0] read_data_1,
    output logic                  read_busy_1,
    input  logic [IDX_W-1:0]      read_index_2,
    output logic [LONG_WIDTH-1:0] read_data_2,
    output logic                  read_busy_2,
    input  logic                  write_enable,
    input  logic [IDX_W-1:0]      write_index,
    input  logic [LONG_WIDTH-1:0] write_data,
    input  logic                  reserve_valid,
    input  logic [IDX_W-1:0]      reserve_index,
    output logic                  reserve_ready,
    output logic [IDX_W:0]        busy_count
);

    localparam int unsigned NUM_REGS = NUM_SHORT + NUM_LONG;
    localparam logic [LONG_WIDTH-1:0] SHORT_MASK = LONG_WIDTH'({SHORT_WIDTH{1'b1}});

    logic [LONG_WIDTH-1:0] regs_q [NUM_REGS];
    logic [LONG_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [IDX_W:0]        busy_count_q, busy_count_d;

    logic [LONG_WIDTH-1:0] write_short;
    logic                  write_clears_busy;
    logic                  reserve_in_range;
    logic                  reserve_busy;

    assign write_short = write_data & SHORT_MASK;
    assign busy_count  = busy_count_q;

    // Reservation is judged against the pre-edge busy bit only.
    always_comb begin
        reserve_in_range = 1'b0;
        reserve_busy     = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (reserve_index == IDX_W'(i)) begin
                reserve_in_range = 1'b1;
                reserve_busy     = busy_q[i];
            end
        end
        reserve_ready = reserve_valid && reserve_in_range && !reserve_busy;
    end

    // Next state. The reserve set is applied after the write clear so that
    // a same-index accepted reserve leaves the register busy. The two can
    // never both change the count for the same index: an accepted reserve
    // implies the bit was clear, so the write had nothing to clear.
    always_comb begin
        regs_d            = regs_q;
        busy_d            = busy_q;
        write_clears_busy = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (write_enable && (write_index == IDX_W'(i))) begin
                regs_d[i]         = (i < NUM_SHORT) ? write_short : write_data;
                busy_d[i]         = 1'b0;
                write_clears_busy = busy_q[i];
            end
            if (reserve_ready && (reserve_index == IDX_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_count_d = busy_count_q + {IDX_W'(0), reserve_ready}
                                    - {IDX_W'(0), write_clears_busy};
    end

    // Read port 1. Out-of-range indices match no entry and read 0 / not busy.
    always_comb begin
        read_data_1 = '0;
        read_busy_1 = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (read_index_1 == IDX_W'(i)) begin
                read_data_1 = regs_q[i];
                read_busy_1 = busy_q[i];
`ifdef REGFILE_BYPASS_EN
                if (write_enable && (write_index == read_index_1)) begin
                    read_data_1 = regs_d[i];
                    read_busy_1 = busy_d[i];
                end
`endif
            end
        end
    end

    // Read port 2, identical to port 1.
    always_comb begin
        read_data_2 = '0;
        read_busy_2 = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (read_index_2 == IDX_W'(i)) begin
                read_data_2 = regs_q[i];
                read_busy_2 = busy_q[i];
`ifdef REGFILE_BYPASS_EN
                if (write_enable && (write_index == read_index_2)) begin
                    read_data_2 = regs_d[i];
                    read_busy_2 = busy_d[i];
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

endmodule
